// File: rtl/id_issue_scheduler_pkg.sv
// Shared types for the ID-stage issue scheduler.
// Drain FSM states, scoreboard entry and source-match helper.
package id_issue_scheduler_pkg;

  localparam logic [4:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DRAIN   = 2'd1,
    SIGNAL  = 2'd2,
    RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic       v;
    logic [4:0] rd;
    logic       ld;
  } sb_entry_t;

  function automatic logic src_match(
    input logic       uses,
    input logic [4:0] r,
    input sb_entry_t  e
  );
    return uses & (r != REG_ZERO) & e.v & (e.rd == r);
  endfunction

endpackage

// File: rtl/id_issue_scheduler_if.sv
// ID-stage request bundle and scheduler decisions.
// master = decode side, slave = scheduler.
interface id_issue_scheduler_if;
  logic       ID_Valid;
  logic [4:0] ID_RegA;
  logic       ID_UsesA;
  logic [4:0] ID_RegB;
  logic       ID_UsesB;
  logic [4:0] ID_WriteReg;
  logic       ID_RegWrite;
  logic       ID_MemRead;
  logic       ID_Syscall;
  logic       ID_IsLLSC;
  logic       Issue;
  logic       Bubble;
  logic       WANT_FREEZE;
  logic       SYS;
  logic       Busy;

  modport master (
    output ID_Valid, ID_RegA, ID_UsesA, ID_RegB, ID_UsesB,
    output ID_WriteReg, ID_RegWrite, ID_MemRead,
    output ID_Syscall, ID_IsLLSC,
    input  Issue, Bubble, WANT_FREEZE, SYS, Busy
  );

  modport slave (
    input  ID_Valid, ID_RegA, ID_UsesA, ID_RegB, ID_UsesB,
    input  ID_WriteReg, ID_RegWrite, ID_MemRead,
    input  ID_Syscall, ID_IsLLSC,
    output Issue, Bubble, WANT_FREEZE, SYS, Busy
  );
endinterface

// File: rtl/id_issue_scheduler_scoreboard.sv
// In-flight destination shift register (EXE, MEM, WB)
// with source comparators producing the ID hazard.
module id_issue_scheduler_scoreboard
  import id_issue_scheduler_pkg::*;
#(
  parameter bit HAS_FORWARDING = 1'b1,
  parameter int SB_DEPTH       = 3
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       i_push,
  input  logic [4:0] i_wreg,
  input  logic       i_ld,
  input  logic [4:0] i_rega,
  input  logic       i_usesa,
  input  logic [4:0] i_regb,
  input  logic       i_usesb,
  output logic       o_hazard
);

  sb_entry_t r_slot [SB_DEPTH];
  logic      w_hazard;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < SB_DEPTH; i++) r_slot[i] <= '0;
    end else begin
      r_slot[0] <= '{v: i_push, rd: i_wreg, ld: i_ld};
      for (int i = 1; i < SB_DEPTH; i++) r_slot[i] <= r_slot[i-1];
    end
  end

  // With bypassing only a load in EXE cannot be forwarded in time.
  always_comb begin
    w_hazard = 1'b0;
    if (HAS_FORWARDING) begin
      w_hazard = r_slot[0].ld &
                 (src_match(i_usesa, i_rega, r_slot[0]) |
                  src_match(i_usesb, i_regb, r_slot[0]));
    end else begin
      for (int i = 0; i < SB_DEPTH; i++) begin
        w_hazard = w_hazard |
                   src_match(i_usesa, i_rega, r_slot[i]) |
                   src_match(i_usesb, i_regb, r_slot[i]);
      end
    end
  end

  assign o_hazard = w_hazard;

endmodule

// File: rtl/id_issue_scheduler.sv
// ID issue/stall controller: hazard stalls plus the
// syscall / LL-SC drain sequence toward fetch.
module id_issue_scheduler
  import id_issue_scheduler_pkg::*;
#(
  parameter bit HAS_FORWARDING = 1'b1,
  parameter int SB_DEPTH       = 3,
  parameter int DRAIN_CYCLES   = 3
) (
  input logic                 CLK,
  input logic                 RESET,
  id_issue_scheduler_if.slave s_id
);

  localparam logic [2:0] CNT_INIT = 3'(DRAIN_CYCLES - 1);

  state_e     r_state;
  state_e     w_next;
  logic [2:0] r_cnt;
  logic [2:0] w_cnt_nxt;
  logic       r_llsc;
  logic       r_sys;
  logic       r_busy;
  logic       w_hazard;
  logic       w_issue;
  logic       w_freeze;
  logic       w_push;

  assign w_push = w_issue & s_id.ID_RegWrite &
                  (s_id.ID_WriteReg != REG_ZERO);

  id_issue_scheduler_scoreboard #(
    .HAS_FORWARDING(HAS_FORWARDING),
    .SB_DEPTH      (SB_DEPTH)
  ) u_sb (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_push  (w_push),
    .i_wreg  (s_id.ID_WriteReg),
    .i_ld    (s_id.ID_MemRead),
    .i_rega  (s_id.ID_RegA),
    .i_usesa (s_id.ID_UsesA),
    .i_regb  (s_id.ID_RegB),
    .i_usesb (s_id.ID_UsesB),
    .o_hazard(w_hazard)
  );

  // A hazard beats a syscall; the syscall retries once the stall clears.
  always_comb begin
    w_next    = r_state;
    w_cnt_nxt = r_cnt;
    w_issue   = 1'b0;
    w_freeze  = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_issue  = s_id.ID_Valid & ~w_hazard;
        w_freeze = s_id.ID_Valid & w_hazard;
        if (w_issue && s_id.ID_Syscall) begin
          w_next    = DRAIN;
          w_cnt_nxt = CNT_INIT;
        end
      end
      DRAIN: begin
        w_freeze = 1'b1;
        if (r_cnt == 3'd0) w_next = SIGNAL;
        else w_cnt_nxt = r_cnt - 3'd1;
      end
      SIGNAL: begin
        w_freeze = 1'b1;
        w_next   = RELEASE;
      end
      RELEASE: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_llsc  <= 1'b0;
      r_sys   <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      r_cnt   <= w_cnt_nxt;
      if (r_state == IDLE && w_next == DRAIN)
        r_llsc <= s_id.ID_IsLLSC;
      r_sys  <= (r_state == SIGNAL) & ~r_llsc;
      r_busy <= (w_next != IDLE);
    end
  end

  assign s_id.Issue       = w_issue;
  assign s_id.Bubble      = ~w_issue;
  assign s_id.WANT_FREEZE = w_freeze;
  assign s_id.SYS         = r_sys;
  assign s_id.Busy        = r_busy;

endmodule

// File: tb/tb_id_issue_scheduler.sv
// Directed bench: hazard vector table on forwarding and
// non-forwarding instances, plus drain/reset sequences.
module tb_id_issue_scheduler;

  logic CLK;
  logic RESET;
  int   n_cmp;
  int   n_err;

  id_issue_scheduler_if f_if ();
  id_issue_scheduler_if n_if ();

  assign n_if.ID_Valid    = f_if.ID_Valid;
  assign n_if.ID_RegA     = f_if.ID_RegA;
  assign n_if.ID_UsesA    = f_if.ID_UsesA;
  assign n_if.ID_RegB     = f_if.ID_RegB;
  assign n_if.ID_UsesB    = f_if.ID_UsesB;
  assign n_if.ID_WriteReg = f_if.ID_WriteReg;
  assign n_if.ID_RegWrite = f_if.ID_RegWrite;
  assign n_if.ID_MemRead  = f_if.ID_MemRead;
  assign n_if.ID_Syscall  = f_if.ID_Syscall;
  assign n_if.ID_IsLLSC   = f_if.ID_IsLLSC;

  id_issue_scheduler #(
    .HAS_FORWARDING(1'b1), .SB_DEPTH(3), .DRAIN_CYCLES(3)
  ) u_fwd (.CLK(CLK), .RESET(RESET), .s_id(f_if));

  id_issue_scheduler #(
    .HAS_FORWARDING(1'b0), .SB_DEPTH(3), .DRAIN_CYCLES(3)
  ) u_nfw (.CLK(CLK), .RESET(RESET), .s_id(n_if));

  initial CLK = 1'b0;
  always #10 CLK = ~CLK;

  typedef struct {
    logic       v;
    logic [4:0] ra;
    logic       ua;
    logic [4:0] rb;
    logic       ub;
    logic [4:0] wr;
    logic       rw;
    logic       mr;
    logic       ei_f;
    logic       ef_f;
    logic       ei_n;
    logic       ef_n;
  } vec_t;

  vec_t tv [30];

  function automatic vec_t mk(
    input logic v, input logic [4:0] ra, input logic ua,
    input logic [4:0] rb, input logic ub,
    input logic [4:0] wr, input logic rw, input logic mr,
    input logic eif, input logic eff,
    input logic ein, input logic efn
  );
    vec_t t;
    t.v = v; t.ra = ra; t.ua = ua; t.rb = rb; t.ub = ub;
    t.wr = wr; t.rw = rw; t.mr = mr;
    t.ei_f = eif; t.ef_f = eff; t.ei_n = ein; t.ef_n = efn;
    return t;
  endfunction

  task automatic chk(input string nm, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(
    input logic v, input logic [4:0] ra, input logic ua,
    input logic [4:0] rb, input logic ub,
    input logic [4:0] wr, input logic rw, input logic mr,
    input logic sc, input logic ll
  );
    f_if.ID_Valid = v; f_if.ID_RegA = ra; f_if.ID_UsesA = ua;
    f_if.ID_RegB = rb; f_if.ID_UsesB = ub; f_if.ID_WriteReg = wr;
    f_if.ID_RegWrite = rw; f_if.ID_MemRead = mr;
    f_if.ID_Syscall = sc; f_if.ID_IsLLSC = ll;
  endtask

  task automatic chk_both(
    input string nm, input logic ei, input logic ef,
    input logic es, input logic eb
  );
    chk({nm, ".f.issue"}, f_if.Issue, ei);
    chk({nm, ".f.bubble"}, f_if.Bubble, ~ei);
    chk({nm, ".f.freeze"}, f_if.WANT_FREEZE, ef);
    chk({nm, ".f.sys"}, f_if.SYS, es);
    chk({nm, ".f.busy"}, f_if.Busy, eb);
    chk({nm, ".n.issue"}, n_if.Issue, ei);
    chk({nm, ".n.freeze"}, n_if.WANT_FREEZE, ef);
    chk({nm, ".n.sys"}, n_if.SYS, es);
    chk({nm, ".n.busy"}, n_if.Busy, eb);
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge CLK);
    RESET = 1'b1;
  endtask

  task automatic run_sys(input logic ll);
    logic ei [7];
    logic ef [7];
    logic es [7];
    logic eb [7];
    ei = '{1, 0, 0, 0, 0, 0, 1};
    ef = '{0, 1, 1, 1, 1, 0, 0};
    es = '{0, 0, 0, 0, 0, ~ll, 0};
    eb = '{0, 1, 1, 1, 1, 1, 0};
    for (int k = 0; k < 7; k++) begin
      @(negedge CLK);
      // cycle 5 presents another syscall while in RELEASE
      drive(1, 0, 0, 0, 0, 0, 0, 0, (k == 0 || k == 5), ll);
      #2;
      chk_both($sformatf("sys%0b.c%0d", ll, k), ei[k], ef[k], es[k], eb[k]);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    RESET = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    tv[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[1]  = mk(1, 29, 1, 0, 0, 8, 1, 1, 1, 0, 1, 0);
    tv[2]  = mk(1, 8, 1, 8, 1, 9, 1, 0, 0, 1, 0, 1);
    tv[3]  = mk(1, 8, 1, 8, 1, 9, 1, 0, 1, 0, 0, 1);
    tv[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tv[5]  = tv[4];
    tv[6]  = tv[4];
    tv[7]  = mk(1, 29, 1, 0, 0, 8, 1, 1, 1, 0, 1, 0);
    tv[8]  = mk(1, 7, 1, 7, 1, 9, 1, 0, 1, 0, 1, 0);
    tv[9]  = tv[4];
    tv[10] = tv[4];
    tv[11] = tv[4];
    tv[12] = mk(1, 0, 1, 0, 0, 5, 1, 0, 1, 0, 1, 0);
    tv[13] = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 0, 1);
    tv[14] = tv[13];
    tv[15] = tv[13];
    tv[16] = mk(1, 5, 1, 1, 1, 6, 1, 0, 1, 0, 1, 0);
    tv[17] = tv[4];
    tv[18] = tv[4];
    tv[19] = tv[4];
    tv[20] = mk(1, 29, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0);
    tv[21] = mk(1, 0, 1, 0, 1, 1, 1, 0, 1, 0, 1, 0);
    tv[22] = mk(1, 1, 0, 0, 1, 2, 1, 0, 1, 0, 1, 0);
    tv[23] = mk(1, 29, 1, 1, 1, 0, 0, 0, 1, 0, 0, 1);
    tv[24] = tv[4];
    tv[25] = tv[4];
    tv[26] = mk(1, 29, 1, 0, 0, 3, 1, 1, 1, 0, 1, 0);
    tv[27] = mk(1, 4, 1, 3, 1, 0, 0, 0, 0, 1, 0, 1);
    tv[28] = mk(0, 0, 0, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    tv[29] = tv[4];

    #25;
    RESET = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      drive(tv[i].v, tv[i].ra, tv[i].ua, tv[i].rb, tv[i].ub,
            tv[i].wr, tv[i].rw, tv[i].mr, 0, 0);
      #2;
      chk($sformatf("v%0d.f.issue", i), f_if.Issue, tv[i].ei_f);
      chk($sformatf("v%0d.f.bubble", i), f_if.Bubble, ~tv[i].ei_f);
      chk($sformatf("v%0d.f.freeze", i), f_if.WANT_FREEZE, tv[i].ef_f);
      chk($sformatf("v%0d.n.issue", i), n_if.Issue, tv[i].ei_n);
      chk($sformatf("v%0d.n.bubble", i), n_if.Bubble, ~tv[i].ei_n);
      chk($sformatf("v%0d.n.freeze", i), n_if.WANT_FREEZE, tv[i].ef_n);
      chk($sformatf("v%0d.f.sys", i), f_if.SYS, 1'b0);
      chk($sformatf("v%0d.f.busy", i), f_if.Busy, 1'b0);
    end

    run_sys(1'b0);
    run_sys(1'b1);

    // load-use hazard takes priority over a syscall
    @(negedge CLK);
    drive(1, 29, 1, 0, 0, 8, 1, 1, 0, 0);
    #2;
    chk("hz.c0.issue", f_if.Issue, 1'b1);
    @(negedge CLK);
    drive(1, 8, 1, 0, 0, 0, 0, 0, 1, 0);
    #2;
    chk("hz.c1.issue", f_if.Issue, 1'b0);
    chk("hz.c1.freeze", f_if.WANT_FREEZE, 1'b1);
    chk("hz.c1.busy", f_if.Busy, 1'b0);
    @(negedge CLK);
    #2;
    chk("hz.c2.issue", f_if.Issue, 1'b1);
    chk("hz.c2.freeze", f_if.WANT_FREEZE, 1'b0);
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("hz.c3.issue", f_if.Issue, 1'b0);
    chk("hz.c3.freeze", f_if.WANT_FREEZE, 1'b1);
    chk("hz.c3.busy", f_if.Busy, 1'b1);

    do_reset();

    // reset asserted mid-drain with cnt==1
    @(negedge CLK);
    drive(1, 29, 1, 0, 0, 8, 1, 1, 1, 1);
    #2;
    chk_both("rd.c0", 1, 0, 0, 0);
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_both("rd.c1", 0, 1, 0, 1);
    @(negedge CLK);
    drive(1, 8, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_both("rd.c2", 0, 1, 0, 1);
    #1;
    RESET = 1'b0;
    #1;
    chk("rd.rst.f.busy", f_if.Busy, 1'b0);
    chk("rd.rst.f.sys", f_if.SYS, 1'b0);
    chk("rd.rst.f.freeze", f_if.WANT_FREEZE, 1'b0);
    chk("rd.rst.n.busy", n_if.Busy, 1'b0);
    RESET = 1'b1;
    #1;
    chk("rd.rel.f.issue", f_if.Issue, 1'b1);
    chk("rd.rel.n.issue", n_if.Issue, 1'b1);
    chk("rd.rel.n.freeze", n_if.WANT_FREEZE, 1'b0);
    @(negedge CLK);
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_both("rd.c3", 1, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
